countdown_timer_16: RTL and testbench
=====================================

COUNTDOWN_TIMER_16 -- requirements
Module: countdown_timer_16

Interface
REQ-001 SHALL have parameter BIT_SZ, default 16, giving the counter width in bits.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset on the next posedge).
REQ-004 SHALL have port enable, input, 1 bit: 1 = decrement while running; 0 = hold (pause).
REQ-005 SHALL have port load, input, 1 bit: single-cycle strobe that captures load_value.
REQ-006 SHALL have port load_value, input, BIT_SZ bits: start and reload value.
REQ-007 SHALL have port auto_reload, input, 1 bit: 1 = restart from the reload value at terminal count.
REQ-008 SHALL have port count, output, BIT_SZ bits: current counter value (registered).
REQ-009 SHALL have port busy, output, 1 bit: 1 while the state is RUN (registered).
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking the terminal-count event (registered).
REQ-011 SHALL have port reload_count, output, 8 bits: number of auto-reload events, saturating (registered).

Function
REQ-012 SHALL implement states IDLE and RUN; busy = (state == RUN).
REQ-013 SHALL store load_value in an internal reload register (width BIT_SZ) on every accepted load.
REQ-014 load=1 with load_value != 0, in any state: count <= load_value, state <= RUN, reload_count <= 0, done <= 0.
REQ-015 load=1 with load_value == 0: count <= 0, state <= IDLE, reload_count <= 0, done <= 0 (no terminal event).
REQ-016 RUN, enable=1, count > 1, load=0: count <= count - 1.
REQ-017 RUN, enable=0, load=0: count, state, reload_count held; done <= 0.
REQ-018 RUN, enable=1, count == 1, auto_reload=0, load=0: count <= 0, state <= IDLE, done <= 1 for exactly one cycle.
REQ-019 RUN, enable=1, count == 1, auto_reload=1, load=0: count <= reload register, state stays RUN, done <= 1 for one cycle, reload_count <= reload_count + 1, saturating at 255.
REQ-020 In auto-reload mode, with enable held high, done SHALL pulse every N cycles, where N = the reload value.
REQ-021 IDLE, load=0: count held, done <= 0, and enable has no effect.
REQ-022 load SHALL take priority over decrement and terminal-count handling in the same cycle; no done pulse occurs on that cycle.
REQ-023 auto_reload SHALL be sampled only at the terminal-count cycle and may change at any time.
REQ-024 count SHALL never wrap below 0; arithmetic is unsigned and modulo-free.
REQ-025 done SHALL be 0 on every cycle not covered by REQ-018 or REQ-019.

Reset
REQ-026 When reset=0 at a posedge: count = 0, reload register = 0, state = IDLE, busy = 0, done = 0, reload_count = 0.
REQ-027 reset SHALL take priority over load and enable, including when asserted mid-count.
REQ-028 Initial register values before the first reset SHALL match the REQ-026 values.

Verification
REQ-029 Reset then single shot: load_value=5, load pulse, enable=1, auto_reload=0 -> count 5,4,3,2,1,0; done=1 on the cycle count becomes 0; busy falls at the same time; count then holds 0.
REQ-030 Auto-reload: load_value=3, enable=1, auto_reload=1 for 10 cycles -> count 3,2,1,3,2,1,3,...; done pulses every 3rd cycle; reload_count increments at each pulse.
REQ-031 Pause: load_value=4, enable toggled 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; exactly one done pulse.
REQ-032 Load collision: count=1 in RUN with load=1, load_value=7 -> count=7, done stays 0, busy stays 1.
REQ-033 Reset mid-run: count=0x1234 in RUN, reset=0 for one cycle -> all outputs zero next cycle; no done pulse; enable is then ignored until the next load.
REQ-034 Edge values: load_value=0 -> IDLE with no done; load_value=0xFFFF with auto_reload -> full period of 65535 cycles; reload_count saturates at 255 after 300 reloads (use BIT_SZ=4 to shorten the run).

Source files
------------

// File: rtl/countdown_timer_16.sv
// Loadable down-counter with one-shot and auto-reload modes.
// A done pulse marks each terminal count; reload_count tallies auto-reloads.
module countdown_timer_16 #(
    parameter int BIT_SZ = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [BIT_SZ-1:0] load_value,
    input  logic              auto_reload,
    output logic [BIT_SZ-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [7:0]        reload_count
);

    // state | meaning
    // IDLE  | stopped; count held, enable ignored until the next load
    // RUN   | counting down while enable is high
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [BIT_SZ-1:0] ONE  = {{(BIT_SZ-1){1'b0}}, 1'b1};
    localparam logic [BIT_SZ-1:0] ZERO = '0;

    state_t            state_q;
    state_t            state_d;
    logic [BIT_SZ-1:0] reload_q;
    logic [BIT_SZ-1:0] reload_d;
    logic [BIT_SZ-1:0] count_d;
    logic              done_d;
    logic [7:0]        reload_count_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            reload_q     <= '0;
            count        <= '0;
            done         <= 1'b0;
            reload_count <= 8'd0;
        end else begin
            state_q      <= state_d;
            reload_q     <= reload_d;
            count        <= count_d;
            done         <= done_d;
            reload_count <= reload_count_d;
        end
    end

    // Load wins over decrement and terminal count, so no done pulse on a load cycle.
    always_comb begin
        state_d        = state_q;
        reload_d       = reload_q;
        count_d        = count;
        done_d         = 1'b0;
        reload_count_d = reload_count;

        if (load) begin
            reload_d       = load_value;
            count_d        = load_value;
            reload_count_d = 8'd0;
            state_d        = (load_value != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && enable) begin
            if (count > ONE) begin
                count_d = count - ONE;
            end else if (count == ONE) begin
                done_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                    if (reload_count != 8'hFF) begin
                        reload_count_d = reload_count + 8'd1;
                    end
                end else begin
                    count_d = ZERO;
                    state_d = IDLE;
                end
            end else begin
                // Unreachable zero count in RUN: fall back to IDLE rather than wrap.
                state_d = IDLE;
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer_16.sv
// Self-checking bench for countdown_timer_16: directed vector tables, corner
// sequences and randomized traffic against a behavioural reference model.
module tb_countdown_timer_16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'd0;
    logic        auto_reload = 1'b0;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [7:0]  reload_count;

    countdown_timer_16 #(.BIT_SZ(16)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .load(load),
        .load_value(load_value),
        .auto_reload(auto_reload),
        .count(count),
        .busy(busy),
        .done(done),
        .reload_count(reload_count)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: remaining ticks, whether the timer is armed, events so far.
    int m_count = 0;
    int m_reload = 0;
    bit m_running = 0;
    bit m_done = 0;
    int m_reloads = 0;

    typedef struct {
        bit rst_n;
        bit ld;
        int lv;
        bit en;
        bit ar;
        int exp_count;
        bit exp_busy;
        bit exp_done;
        int exp_rc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit rst_n, bit ld, int lv, bit en, bit ar);
        m_done = 0;
        if (!rst_n) begin
            m_count = 0; m_reload = 0; m_running = 0; m_reloads = 0;
        end else if (ld) begin
            m_reload = lv; m_count = lv; m_running = (lv != 0); m_reloads = 0;
        end else if (m_running && en) begin
            if (m_count == 1) begin
                m_done = 1;
                if (ar) begin
                    m_count = m_reload;
                    m_reloads = (m_reloads + 1 > 255) ? 255 : m_reloads + 1;
                end else begin
                    m_count = 0;
                    m_running = 0;
                end
            end else begin
                m_count = m_count - 1;
            end
        end
    endfunction

    // Apply one cycle of inputs, advance the model, compare all outputs after the edge.
    task automatic tick(input bit rst_n, input bit ld, input int lv, input bit en, input bit ar);
        reset = rst_n; load = ld; load_value = 16'(lv); enable = en; auto_reload = ar;
        @(posedge clock);
        model_step(rst_n, ld, lv, en, ar);
        #1;
        check("model_count", int'(count), m_count);
        check("model_busy", int'(busy), int'(m_running));
        check("model_done", int'(done), int'(m_done));
        check("model_reload_count", int'(reload_count), m_reloads);
    endtask

    vec_t vecs[$];

    task automatic add(input bit r, input bit l, input int lv, input bit e, input bit a,
                       input int c, input bit b, input bit d, input int rc);
        vec_t v;
        v.rst_n = r; v.ld = l; v.lv = lv; v.en = e; v.ar = a;
        v.exp_count = c; v.exp_busy = b; v.exp_done = d; v.exp_rc = rc;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset, then single shot from 5.
        add(0,0,0,1,0,   0,0,0,0);
        add(1,1,5,0,0,   5,1,0,0);
        add(1,0,0,1,0,   4,1,0,0);
        add(1,0,0,1,0,   3,1,0,0);
        add(1,0,0,1,0,   2,1,0,0);
        add(1,0,0,1,0,   1,1,0,0);
        add(1,0,0,1,0,   0,0,1,0);
        add(1,0,0,1,0,   0,0,0,0);
        add(1,0,0,1,1,   0,0,0,0);
        // Pause: enable 1,0,0,1,1,1.
        add(1,1,4,0,0,   4,1,0,0);
        add(1,0,0,1,0,   3,1,0,0);
        add(1,0,0,0,0,   3,1,0,0);
        add(1,0,0,0,0,   3,1,0,0);
        add(1,0,0,1,0,   2,1,0,0);
        add(1,0,0,1,0,   1,1,0,0);
        add(1,0,0,1,0,   0,0,1,0);
        // Load collides with terminal count.
        add(1,1,2,1,0,   2,1,0,0);
        add(1,0,0,1,0,   1,1,0,0);
        add(1,1,7,1,0,   7,1,0,0);
        add(1,0,0,1,0,   6,1,0,0);
        // Auto-reload with period 3.
        add(1,1,3,1,1,   3,1,0,0);
        add(1,0,0,1,1,   2,1,0,0);
        add(1,0,0,1,1,   1,1,0,0);
        add(1,0,0,1,1,   3,1,1,1);
        add(1,0,0,1,1,   2,1,0,1);
        add(1,0,0,1,1,   1,1,0,1);
        add(1,0,0,1,1,   3,1,1,2);
        add(1,0,0,1,0,   2,1,0,2);
        add(1,0,0,1,0,   1,1,0,2);
        add(1,0,0,1,0,   0,0,1,2);
        // Zero load goes idle without a terminal event and clears reload_count.
        add(1,1,0,1,1,   0,0,0,0);
        add(1,0,0,1,1,   0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst_n, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
            check($sformatf("vec%0d_rc", i), int'(reload_count), vecs[i].exp_rc);
        end

        // Reset mid-run beats a simultaneous load; enable is ignored afterwards.
        tick(1, 1, 16'h1234, 1, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 1, 0);
        check("midrun_count", int'(count), 16'h122A);
        tick(0, 1, 9, 1, 1);
        check("midrun_reset_count", int'(count), 0);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_done", int'(done), 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 0);
        check("post_reset_idle_count", int'(count), 0);
        check("post_reset_idle_busy", int'(busy), 0);

        // Reload counter saturates: period 1, 300 reloads.
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 300; i++) tick(1, 0, 0, 1, 1);
        check("sat_reload_count", int'(reload_count), 255);
        check("sat_done", int'(done), 1);
        check("sat_count", int'(count), 1);

        // Full 16-bit period with auto-reload.
        tick(1, 1, 16'hFFFF, 1, 1);
        for (int i = 0; i < 65534; i++) tick(1, 0, 0, 1, 1);
        check("full_pre_count", int'(count), 1);
        check("full_pre_done", int'(done), 0);
        tick(1, 0, 0, 1, 1);
        check("full_wrap_count", int'(count), 16'hFFFF);
        check("full_wrap_done", int'(done), 1);
        check("full_wrap_rc", int'(reload_count), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, l, e, a;
            int v;
            r = ($urandom_range(0, 63) != 0);
            l = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 1) == 1;
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6));
            tick(r, l, v, e, a);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
